// File: rtl/arm_reg_file.sv
// ARM register file: R0-R14 general purpose and R15 as a self-advancing PC.
// It has one write-back port, three combinational read ports, and R15 reads return PC+8.
module arm_reg_file #(
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  PC_RESET    = '0,
    parameter logic [DATA_W-1:0]  PC_INC      = DATA_W'(4),
    parameter logic [DATA_W-1:0]  PC_READ_OFS = DATA_W'(8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              pc_en,
    input  logic [3:0]        ra_a,
    input  logic [3:0]        ra_b,
    input  logic [3:0]        ra_c,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [DATA_W-1:0] rd_c,
    output logic [DATA_W-1:0] pc_out
);

    logic [15:0]       ld_en;
    logic [DATA_W-1:0] gpr_q [0:14];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    logic [DATA_W-1:0] rview [0:15];

    // 4-to-16 write decoder: at most one load enable is high per cycle
    always_comb begin
        ld_en = '0;
        if (we) begin
            ld_en[wa] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 15; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 15; i++) begin
                if (ld_en[i]) begin
                    gpr_q[i] <= wd;
                end
            end
        end
    end

    // A write-back to R15 wins over the fetch increment and is word-aligned
    always_comb begin
        pc_d = pc_q;
        if (ld_en[15]) begin
            pc_d = {wd[DATA_W-1:2], 2'b00};
        end else if (pc_en) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 15; i++) begin
            rview[i] = gpr_q[i];
        end
        rview[15] = pc_q + PC_READ_OFS;
    end

    assign rd_a   = rview[ra_a];
    assign rd_b   = rview[ra_b];
    assign rd_c   = rview[ra_c];
    assign pc_out = pc_q;

endmodule
